tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_checker.sv | 152 +++++++++++++++
 tb/tb_tt_sweep_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustively sweeps an N-bit stimulus vector into two
// implementations of the same function and counts output mismatches.
// Each vector is held SETTLE cycles, then compared for one CHECK cycle.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a sweep (accepted in IDLE or DONE only)
//   vec        [N-1:0] stimulus driven to both implementations
//   y_a, y_b   reference / comparison implementation outputs
//   busy       sweep in progress (SETTLE or CHECK)
//   done       sweep finished; held until restart or reset
//   err_cnt    [N:0] number of mismatching vectors
//   fail_vec   [N-1:0] first mismatching vector (valid when fail_seen)
//   fail_seen  a mismatch has been seen in the current sweep
//
// Optional feature: define TT_STOP_ON_FAIL_EN to end the sweep at the first
// mismatch, leaving vec on the failing vector.
module tt_sweep_checker #(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] vec,
  input  logic         y_a,
  input  logic         y_b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] fail_vec,
  output logic         fail_seen
);

  localparam int unsigned ERR_W  = N + 1;
  localparam int unsigned WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N-1:0]      VEC_LAST  = {N{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      vec_q, vec_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [N-1:0]      fail_vec_q, fail_vec_d;
  logic              fail_seen_q, fail_seen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch_c;

  assign mismatch_c = y_a ^ y_b;

  // Next-state and next-result computation.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    wait_d      = wait_q;
    err_cnt_d   = err_cnt_q;
    fail_vec_d  = fail_vec_q;
    fail_seen_d = fail_seen_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Restart from DONE clears the previous results on the same edge.
        if (start) begin
          state_d     = S_SETTLE;
          vec_d       = '0;
          wait_d      = '0;
          err_cnt_d   = '0;
          fail_vec_d  = '0;
          fail_seen_d = 1'b0;
        end
      end
      S_SETTLE: begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_LAST) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch_c) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!fail_seen_q) begin
            fail_vec_d  = vec_q;
            fail_seen_d = 1'b1;
          end
        end
`ifdef TT_STOP_ON_FAIL_EN
        if (mismatch_c || (vec_q == VEC_LAST)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + N'(1);
          wait_d  = '0;
        end
`else
        // Last vector holds at all-ones; no wrap back to zero.
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + N'(1);
          wait_d  = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags follow the next state so they are registered with it.
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      wait_q      <= '0;
      err_cnt_q   <= '0;
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      wait_q      <= wait_d;
      err_cnt_q   <= err_cnt_d;
      fail_vec_q  <= fail_vec_d;
      fail_seen_q <= fail_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = err_cnt_q;
  assign fail_vec  = fail_vec_q;
  assign fail_seen = fail_seen_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: an N=3/SETTLE=1 instance comparing a
// majority function against selectable faulty copies, and an N=4/SETTLE=2
// instance comparing two parity implementations.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start3, start4;
  logic [2:0] vec3;
  logic [3:0] vec4;
  logic y_a3, y_b3, y_a4, y_b4;
  logic busy3, done3, fail_seen3;
  logic busy4, done4, fail_seen4;
  logic [3:0] err3;
  logic [4:0] err4;
  logic [2:0] fail_vec3;
  logic [3:0] fail_vec4;
  int mode;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  // Reference: gate-level majority. Comparison copy: majority with a planted fault.
  assign y_a3 = (vec3[0] & vec3[1]) | (vec3[0] & vec3[2]) | (vec3[1] & vec3[2]);
  assign y_b3 = ((vec3 >= 3'd3) ? (vec3 != 3'd4) : 1'b0) ^
                ((mode == 1) ? (vec3 == 3'd5) :
                 (mode == 2) ? 1'b1 :
                 (mode == 3) ? (vec3 == 3'd2) : 1'b0);
  assign y_a4 = vec4[0] ^ vec4[1] ^ vec4[2] ^ vec4[3];
  assign y_b4 = ^vec4;

  tt_sweep_checker #(.N(3), .SETTLE(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vec(vec3), .y_a(y_a3), .y_b(y_b3),
    .busy(busy3), .done(done3), .err_cnt(err3), .fail_vec(fail_vec3),
    .fail_seen(fail_seen3)
  );

  tt_sweep_checker #(.N(4), .SETTLE(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .vec(vec4), .y_a(y_a4), .y_b(y_b4),
    .busy(busy4), .done(done4), .err_cnt(err4), .fail_vec(fail_vec4),
    .fail_seen(fail_seen4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut3, check cleared results right after the start edge,
  // then count edges until done (bounded).
  task automatic sweep3(input string tag, output int edges);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy3), 32'd1);
    check({tag, "_err_cleared"}, 32'(err3), 32'd0);
    check({tag, "_seen_cleared"}, 32'(fail_seen3), 32'd0);
    edges = 0;
    while (done3 !== 1'b1 && edges < 200) begin
      tick();
      edges++;
      if (busy3 && done3) overlap++;
    end
  endtask

  initial begin
    int edges;
    int vec_bad;
    mode   = 0;
    rst    = 1'b1;
    start3 = 1'b0;
    start4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_vec", 32'(vec3), 32'd0);
    check("rst_err", 32'(err3), 32'd0);
    check("rst_fail_vec", 32'(fail_vec3), 32'd0);
    check("rst_fail_seen", 32'(fail_seen3), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);

    // Identical implementations.
    mode = 0;
    sweep3("same", edges);
    check("same_edges", 32'(edges), 32'd16);
    check("same_err", 32'(err3), 32'd0);
    check("same_seen", 32'(fail_seen3), 32'd0);
    check("same_vec", 32'(vec3), 32'd7);
    check("same_busy", 32'(busy3), 32'd0);
    tick();
    tick();
    check("same_done_held", 32'(done3), 32'd1);

    // Single mismatch at 101.
    mode = 1;
    sweep3("one", edges);
`ifdef TT_STOP_ON_FAIL_EN
    check("one_edges", 32'(edges), 32'd12);
    check("one_vec", 32'(vec3), 32'd5);
`else
    check("one_edges", 32'(edges), 32'd16);
    check("one_vec", 32'(vec3), 32'd7);
`endif
    check("one_err", 32'(err3), 32'd1);
    check("one_fail_vec", 32'(fail_vec3), 32'd5);
    check("one_seen", 32'(fail_seen3), 32'd1);

    // Every vector mismatches, then restart from DONE and repeat.
    mode = 2;
    for (int r = 0; r < 2; r++) begin
      sweep3((r == 0) ? "all" : "all_again", edges);
`ifdef TT_STOP_ON_FAIL_EN
      check("all_edges", 32'(edges), 32'd2);
      check("all_err", 32'(err3), 32'd1);
`else
      check("all_edges", 32'(edges), 32'd16);
      check("all_err", 32'(err3), 32'd8);
`endif
      check("all_fail_vec", 32'(fail_vec3), 32'd0);
      check("all_seen", 32'(fail_seen3), 32'd1);
    end

    // Single mismatch at 010.
    mode = 3;
    sweep3("two", edges);
`ifdef TT_STOP_ON_FAIL_EN
    check("two_edges", 32'(edges), 32'd6);
    check("two_vec", 32'(vec3), 32'd2);
`else
    check("two_edges", 32'(edges), 32'd16);
    check("two_vec", 32'(vec3), 32'd7);
`endif
    check("two_err", 32'(err3), 32'd1);
    check("two_fail_vec", 32'(fail_vec3), 32'd2);

    // start held high through the sweep, reset on edge 7 aborts it.
    mode   = 3;
    start3 = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) tick();
`ifdef TT_STOP_ON_FAIL_EN
    check("hold_vec_e6", 32'(vec3), 32'd2);
    check("hold_done_e6", 32'(done3), 32'd1);
`else
    check("hold_vec_e6", 32'(vec3), 32'd3);
    check("hold_busy_e6", 32'(busy3), 32'd1);
`endif
    check("hold_err_e6", 32'(err3), 32'd1);
    rst    = 1'b1;
    start3 = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy3), 32'd0);
    check("abort_done", 32'(done3), 32'd0);
    check("abort_vec", 32'(vec3), 32'd0);
    check("abort_err", 32'(err3), 32'd0);
    check("abort_seen", 32'(fail_seen3), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("abort_no_restart", 32'(busy3), 32'd0);

    // Reset wins over start on the same edge.
    rst    = 1'b1;
    start3 = 1'b1;
    tick();
    rst    = 1'b0;
    start3 = 1'b0;
    check("rst_over_start", 32'(busy3), 32'd0);

    // N=4, SETTLE=2: each vector held three cycles, done after 48 edges.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("n4_vec_e0", 32'(vec4), 32'd0);
    edges   = 0;
    vec_bad = 0;
    while (done4 !== 1'b1 && edges < 200) begin
      tick();
      edges++;
      if (busy4 && done4) overlap++;
      if (edges < 48 && vec4 !== 4'(edges / 3)) vec_bad++;
    end
    check("n4_edges", 32'(edges), 32'd48);
    check("n4_vec_hold", 32'(vec_bad), 32'd0);
    check("n4_vec_end", 32'(vec4), 32'd15);
    check("n4_err", 32'(err4), 32'd0);
    check("n4_fail_vec", 32'(fail_vec4), 32'd0);
    check("n4_seen", 32'(fail_seen4), 32'd0);

    check("busy_done_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
